// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, one-cycle stall FSM,
// flush-driven bubble insertion and a saturating bubble counter.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] ID_ctrl,
    input  logic [3:0]  ID_ALU_op,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic [4:0]  ID_rd,
    input  logic [31:0] ID_rs1_data,
    input  logic [31:0] ID_rs2_data,
    input  logic [31:0] ID_PC,
    input  logic [31:0] ID_imm,
    input  logic        EX_flush,
    output logic [12:0] EX_ctrl,
    output logic [3:0]  EX_ALU_op,
    output logic [4:0]  EX_rd,
    output logic [31:0] EX_rs1_data,
    output logic [31:0] EX_rs2_data,
    output logic [31:0] EX_PC,
    output logic [31:0] EX_imm,
    output logic        EX_valid,
    output logic        hazard_stall,
    output logic [7:0]  bubble_count,
    output logic        dbg_state
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam int LOAD_BIT = 12;

    state_t state, state_next;
    logic   uses_rs2;
    logic   load_use;
    logic   id_nop;
    logic   insert_bubble;

    // Shift-immediate encodings 001/011 carry no rs2 operand.
    assign uses_rs2 = !((ID_ctrl[2:0] == 3'b001) || (ID_ctrl[2:0] == 3'b011));
    assign load_use = EX_valid && EX_ctrl[LOAD_BIT] && (EX_rd != 5'd0) &&
                      ((EX_rd == ID_rs1) || (uses_rs2 && (EX_rd == ID_rs2)));
    assign id_nop   = (ID_ctrl == 13'd0) && (ID_ALU_op == 4'd0);
    assign dbg_state = state;

    always_comb begin
        state_next    = state;
        hazard_stall  = 1'b0;
        insert_bubble = 1'b0;
        case (state)
            RUN: begin
                if (EX_flush) begin
                    insert_bubble = 1'b1;
                end else if (rst_n && load_use) begin
                    hazard_stall  = 1'b1;
                    insert_bubble = 1'b1;
                    state_next    = STALL;
                end
            end
            STALL: begin
                // ID was frozen for one cycle; replay it unless a flush kills it.
                if (EX_flush) insert_bubble = 1'b1;
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            EX_ctrl      <= 13'd0;
            EX_ALU_op    <= 4'd0;
            EX_rd        <= 5'd0;
            EX_rs1_data  <= 32'd0;
            EX_rs2_data  <= 32'd0;
            EX_PC        <= 32'd0;
            EX_imm       <= 32'd0;
            EX_valid     <= 1'b0;
            bubble_count <= 8'd0;
        end else if (insert_bubble) begin
            // Bubble clears control only; data fields keep their old values.
            EX_ctrl   <= 13'd0;
            EX_ALU_op <= 4'd0;
            EX_rd     <= 5'd0;
            EX_valid  <= 1'b0;
            if (bubble_count != 8'hFF) bubble_count <= bubble_count + 8'd1;
        end else begin
            EX_ctrl     <= ID_ctrl;
            EX_ALU_op   <= ID_ALU_op;
            EX_rd       <= ID_rd;
            EX_rs1_data <= ID_rs1_data;
            EX_rs2_data <= ID_rs2_data;
            EX_PC       <= ID_PC;
            EX_imm      <= ID_imm;
            EX_valid    <= !id_nop;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage: driver pushes expectations from a
// behavioural pipeline model, monitors pop and compare against DUT outputs.
module tb_id_ex_stage;

    localparam int W = 160;

    typedef struct {
        logic [12:0] ctrl;
        logic [3:0]  alu;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] a, b, pc, imm;
        logic        flush;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] ID_ctrl = '0;
    logic [3:0]  ID_ALU_op = '0;
    logic [4:0]  ID_rs1 = '0, ID_rs2 = '0, ID_rd = '0;
    logic [31:0] ID_rs1_data = '0, ID_rs2_data = '0, ID_PC = '0, ID_imm = '0;
    logic        EX_flush = 1'b0;
    logic [12:0] EX_ctrl;
    logic [3:0]  EX_ALU_op;
    logic [4:0]  EX_rd;
    logic [31:0] EX_rs1_data, EX_rs2_data, EX_PC, EX_imm;
    logic        EX_valid, hazard_stall, dbg_state;
    logic [7:0]  bubble_count;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ID_ctrl(ID_ctrl), .ID_ALU_op(ID_ALU_op),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
        .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data),
        .ID_PC(ID_PC), .ID_imm(ID_imm), .EX_flush(EX_flush),
        .EX_ctrl(EX_ctrl), .EX_ALU_op(EX_ALU_op), .EX_rd(EX_rd),
        .EX_rs1_data(EX_rs1_data), .EX_rs2_data(EX_rs2_data),
        .EX_PC(EX_PC), .EX_imm(EX_imm), .EX_valid(EX_valid),
        .hazard_stall(hazard_stall), .bubble_count(bubble_count),
        .dbg_state(dbg_state)
    );

    // clock/reset block
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];
    logic         hs_q[$];

    // reference model: what EX should hold, and whether the pipeline is frozen
    logic [12:0] m_ctrl;
    logic [3:0]  m_alu;
    logic [4:0]  m_rd;
    logic        m_valid;
    logic [31:0] m_a, m_b, m_pc, m_imm;
    int          m_bc;
    logic        m_stalled;
    logic        last_hs;

    task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] dut_bundle();
        return {EX_ctrl, EX_ALU_op, EX_rd, EX_valid, EX_rs1_data, EX_rs2_data,
                EX_PC, EX_imm, bubble_count, dbg_state};
    endfunction

    function automatic logic [W-1:0] model_bundle();
        return {m_ctrl, m_alu, m_rd, m_valid, m_a, m_b, m_pc, m_imm, 8'(m_bc), m_stalled};
    endfunction

    task automatic model_reset();
        m_ctrl = '0; m_alu = '0; m_rd = '0; m_valid = 1'b0;
        m_a = '0; m_b = '0; m_pc = '0; m_imm = '0;
        m_bc = 0; m_stalled = 1'b0; last_hs = 1'b0;
    endtask

    function automatic stim_t mk(input logic [12:0] c, input logic [3:0] alu,
                                 input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [4:0] rd, input logic f);
        stim_t s;
        s.ctrl = c; s.alu = alu; s.rs1 = r1; s.rs2 = r2; s.rd = rd; s.flush = f;
        s.a = $urandom; s.b = $urandom; s.pc = $urandom; s.imm = $urandom;
        return s;
    endfunction

    // Drive ID inputs for the coming edge and push the expected responses.
    task automatic apply(input stim_t s);
        logic dep, exp_hs;
        ID_ctrl = s.ctrl; ID_ALU_op = s.alu; ID_rs1 = s.rs1; ID_rs2 = s.rs2;
        ID_rd = s.rd; ID_rs1_data = s.a; ID_rs2_data = s.b; ID_PC = s.pc;
        ID_imm = s.imm; EX_flush = s.flush;
        dep = (m_rd == s.rs1) ||
              (!(s.ctrl[2:0] == 3'b001 || s.ctrl[2:0] == 3'b011) && (m_rd == s.rs2));
        exp_hs = !m_stalled && !s.flush && m_valid && m_ctrl[12] && (m_rd != 0) && dep;
        hs_q.push_back(exp_hs);
        if (s.flush || exp_hs) begin
            m_ctrl = '0; m_alu = '0; m_rd = '0; m_valid = 1'b0;
            m_bc = (m_bc < 255) ? m_bc + 1 : 255;
            m_stalled = exp_hs;
        end else begin
            m_ctrl = s.ctrl; m_alu = s.alu; m_rd = s.rd;
            m_valid = !(s.ctrl == 0 && s.alu == 0);
            m_a = s.a; m_b = s.b; m_pc = s.pc; m_imm = s.imm;
            m_stalled = 1'b0;
        end
        last_hs = exp_hs;
        exp_q.push_back(model_bundle());
    endtask

    // driver tasks
    task automatic drive_cycle(input stim_t s);
        @(negedge clk);
        #1;
        apply(s);
        @(posedge clk);
    endtask

    task automatic reset_pulse(input stim_t s);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("reset_outputs", dut_bundle(), '0);
        check_val("reset_hazard", W'(hazard_stall), '0);
        rst_n = 1'b1;
        model_reset();
        apply(s);
        @(posedge clk);
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        #3;
        if (hs_q.size() > 0) check_val("hazard_stall", W'(hazard_stall), W'(hs_q.pop_front()));
    end

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) check_val("ex_bundle", dut_bundle(), exp_q.pop_front());
    end

    localparam logic [12:0] LW  = 13'h1C10;
    localparam logic [12:0] ADD = 13'h0800;

    initial begin
        stim_t s;
        model_reset();
        #2;
        check_val("reset_initial", dut_bundle(), '0);

        // capture of an ADD, then load-use stall and replay
        reset_pulse(mk(ADD, 4'b0010, 5'd1, 5'd2, 5'd5, 1'b0));
        drive_cycle(mk(LW, 4'd0, 5'd3, 5'd0, 5'd7, 1'b0));
        s = mk(ADD, 4'b0010, 5'd7, 5'd4, 5'd8, 1'b0);
        drive_cycle(s);
        drive_cycle(s);
        // rd zero never hazards
        drive_cycle(mk(LW, 4'd0, 5'd3, 5'd0, 5'd0, 1'b0));
        drive_cycle(mk(ADD, 4'b0010, 5'd0, 5'd0, 5'd9, 1'b0));
        // rs2 ignored for shift-immediate 001/011, used otherwise
        drive_cycle(mk(LW, 4'd0, 5'd3, 5'd0, 5'd9, 1'b0));
        drive_cycle(mk(ADD | 13'd1, 4'b0001, 5'd1, 5'd9, 5'd10, 1'b0));
        drive_cycle(mk(LW, 4'd0, 5'd3, 5'd0, 5'd9, 1'b0));
        drive_cycle(mk(ADD | 13'd3, 4'b0101, 5'd1, 5'd9, 5'd10, 1'b0));
        drive_cycle(mk(LW, 4'd0, 5'd3, 5'd0, 5'd9, 1'b0));
        s = mk(ADD, 4'b0010, 5'd1, 5'd9, 5'd10, 1'b0);
        drive_cycle(s);
        drive_cycle(s);
        // flush beats hazard
        drive_cycle(mk(LW, 4'd0, 5'd3, 5'd0, 5'd7, 1'b0));
        drive_cycle(mk(ADD, 4'b0010, 5'd7, 5'd0, 5'd8, 1'b1));
        // decoded NOP captured as invalid
        drive_cycle(mk(13'd0, 4'd0, 5'd1, 5'd2, 5'd3, 1'b0));
        // async reset in the middle of a stall
        drive_cycle(mk(LW, 4'd0, 5'd3, 5'd0, 5'd7, 1'b0));
        s = mk(ADD, 4'b0010, 5'd7, 5'd0, 5'd8, 1'b0);
        drive_cycle(s);
        reset_pulse(s);

        // random traffic; a stalled instruction is held in ID for its replay
        s = mk(ADD, 4'b0010, 5'd1, 5'd2, 5'd3, 1'b0);
        for (int i = 0; i < 500; i++) begin
            if (last_hs) begin
                s.flush = ($urandom_range(0, 7) == 0);
            end else begin
                s = mk(13'($urandom_range(0, 8191)), 4'($urandom_range(0, 15)),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
                if ($urandom_range(0, 9) == 0) begin
                    s.ctrl = '0;
                    s.alu = '0;
                end
            end
            drive_cycle(s);
        end

        // saturation under a long flush run
        for (int i = 0; i < 300; i++) begin
            drive_cycle(mk(13'($urandom_range(0, 8191)), 4'($urandom_range(0, 15)),
                           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                           5'($urandom_range(0, 31)), 1'b1));
        end
        @(negedge clk);
        check_val("bubble_sat", W'(bubble_count), W'(255));

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0 || hs_q.size() != 0) begin
            bad++;
            $display("FAIL drain act=%0d pending exp=0", exp_q.size() + hs_q.size());
        end

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL use: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 The block SHALL use: rst_n  in  1  asynchronous, active-low reset.
REQ-003 The block SHALL accept: ID_ctrl  in  13  decoded control bundle {ID_load_Instr, ID_RF_enable, RAM_Enable, RAM_RW, RAM_SE, JALR_Instr, JAL_Instr, AUIPC_Instr, RAM_Size[1:0], ID_shift_imm[2:0]}, MSB first.
REQ-004 The block SHALL accept: ID_ALU_op  in  4  ALU operation from decode.
REQ-005 The block SHALL accept: ID_rs1, ID_rs2, ID_rd  in  5 each  register indices from Instruction[19:15], [24:20], [11:7].
REQ-006 The block SHALL accept: ID_rs1_data, ID_rs2_data, ID_PC, ID_imm  in  32 each  operand, PC and immediate values.
REQ-007 The block SHALL accept: EX_flush  in  1  taken branch/jump resolved in EX.
REQ-008 The block SHALL drive: EX_ctrl  out  13, EX_ALU_op  out  4, EX_rd  out  5, EX_rs1_data, EX_rs2_data, EX_PC, EX_imm  out  32 each  registered copies.
REQ-009 The block SHALL drive: EX_valid  out  1  high when EX holds a real instruction.
REQ-010 The block SHALL drive: hazard_stall  out  1  combinational, freezes PC and IF/ID when high.
REQ-011 The block SHALL drive: bubble_count  out  8  saturating count of inserted bubbles.

Function
REQ-012 Load-use hazard SHALL be flagged when EX_valid & EX_ctrl load bit & EX_rd!=0 & (EX_rd==ID_rs1 | EX_rd==ID_rs2).
REQ-013 The rs2 comparison SHALL be skipped when ID shift_imm is 001 or 011 (no rs2 operand).
REQ-014 FSM states SHALL be RUN and STALL; reset state RUN.
REQ-015 In RUN with hazard and no EX_flush: hazard_stall=1, EX loads a bubble, next state STALL.
REQ-016 In STALL: hazard_stall=0, EX loads the held ID bundle normally, next state RUN.
REQ-017 STALL SHALL last exactly one cycle; a back-to-back load chain re-enters STALL only via a fresh REQ-012 match.
REQ-018 A bubble SHALL set EX_ctrl=0, EX_ALU_op=0, EX_rd=0, EX_valid=0; data outputs hold prior values.
REQ-019 EX_flush SHALL take priority over hazard: EX loads a bubble, hazard_stall=0, next state RUN.
REQ-020 Normal capture (RUN, no hazard, no flush) SHALL have one-cycle latency: ID inputs appear on EX outputs after the next rising edge, EX_valid=1.
REQ-021 An all-zero ID_ctrl with ID_RF_enable=0 and ID_ALU_op=0 (decoded NOP) SHALL be captured with EX_valid=0.
REQ-022 bubble_count SHALL increment by 1 per bubble from REQ-015 or REQ-019, saturating at 255, never wrapping.
REQ-023 hazard_stall SHALL depend only on current EX registers and ID inputs, no extra latency.

Reset
REQ-024 rst_n low SHALL immediately clear all EX outputs, EX_valid, and bubble_count to 0 and force state RUN, independent of clk.
REQ-025 Reset asserted mid-STALL SHALL abandon the stall; first edge after deassertion captures ID inputs per REQ-020.
REQ-026 hazard_stall SHALL be 0 while rst_n is low.

Verification
REQ-027 Capture: ID ADD (ALU_op 0010, rd=5, RF_enable=1), no hazard -> next edge EX_ALU_op=0010, EX_rd=5, EX_valid=1, hazard_stall=0.
REQ-028 Load-use: EX holds LW rd=7, ID rs1=7 -> hazard_stall=1; next edge EX_valid=0, EX_ctrl=0, bubble_count=1; following edge dependent instruction in EX, EX_valid=1.
REQ-029 rd zero: EX holds LW rd=0, ID rs1=0 -> hazard_stall=0, no bubble.
REQ-030 Flush vs hazard: load-use match with EX_flush=1 -> hazard_stall=0, EX bubble, state RUN, bubble_count+1.
REQ-031 Saturation: 300 consecutive EX_flush cycles -> bubble_count=255.
REQ-032 Async reset: pulse rst_n low between edges during STALL -> outputs 0 immediately; next edge normal capture.
